seg_scan_driver: RTL and testbench

Time-multiplexed scan driver sitting directly upstream of the seven-segment decoder in the watch controller. Holds a per-digit character buffer (4-bit code plus NUMBER/ALPHABET mode), cycles one digit at a time at a programmable rate, and presents the active digit's `value`/`mode` to the decoder with a one-hot digit enable. Provides anti-ghosting blanking, per-digit blinking for time-set editing, and a frame-boundary pulse for the controller.

---
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed scan driver in front of the seven-segment decoder.
// Keeps a per-digit {value, mode} buffer and walks one digit at a time.
// Each digit stays lit for SCAN_DIV-1 clocks, then gets one blank clock
// so the next digit does not ghost. Digits can blink for time-set editing.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   wr_en/wr_addr     : write one buffer slot (out-of-range addresses ignored)
//   wr_value/wr_mode  : data for the write (mode 0 NUMBER, 1 ALPHABET)
//   clear             : blank every slot; a same-cycle write still lands
//   blink_mask        : digits to blank during the off phase of the blink
//   value/mode        : active digit's character, to the decoder
//   digit_en          : one-hot common enable, all zero in the gap cycle
//   frame_tick        : one-cycle pulse at the end of each full scan frame
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_value,
    input  logic                  wr_mode,
    input  logic                  clear,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [3:0]            value,
    output logic                  mode,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int PCNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0][3:0] slot_val_q, slot_val_d;
    logic [NUM_DIGITS-1:0]      slot_mode_q, slot_mode_d;

    logic [3:0]            value_q, value_d;
    logic                  mode_q, mode_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  pcnt_wrap, frame_end;
    logic [3:0]            sel_val;
    logic                  sel_mode, sel_blink;
    logic [NUM_DIGITS-1:0] sel_onehot;

    always_comb begin
        pcnt_wrap = (pcnt_q == PCNT_LAST);
        frame_end = pcnt_wrap && (idx_q == IDX_LAST);

        pcnt_d = pcnt_wrap ? '0 : pcnt_q + 1'b1;

        idx_d = idx_q;
        if (pcnt_wrap)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // Blink phase only moves on frame boundaries, never mid-digit.
        bcnt_d        = bcnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d        = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // Clear first, then the write, so a colliding write wins its slot.
        slot_val_d  = slot_val_q;
        slot_mode_d = slot_mode_q;
        if (clear) begin
            slot_val_d  = '0;
            slot_mode_d = '1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && (wr_addr == 3'(i))) begin
                slot_val_d[i]  = wr_value;
                slot_mode_d[i] = wr_mode;
            end
        end

        // Mux by compare rather than direct index so non-power-of-two
        // digit counts never read past the buffer.
        sel_val    = 4'd0;
        sel_mode   = 1'b1;
        sel_blink  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_val       = slot_val_q[i];
                sel_mode      = slot_mode_q[i];
                sel_blink     = blink_mask[i];
                sel_onehot[i] = 1'b1;
            end
        end

        // Blinked digit shows alphabet space but keeps its enable, so the
        // scan duty cycle seen by the display never changes.
        value_d      = (blink_phase_q && sel_blink) ? 4'd0 : sel_val;
        mode_d       = (blink_phase_q && sel_blink) ? 1'b1 : sel_mode;
        digit_en_d   = (pcnt_q == '0) ? '0 : sel_onehot;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            bcnt_q        <= '0;
            blink_phase_q <= 1'b0;
            slot_val_q    <= '0;
            slot_mode_q   <= '1;
            value_q       <= 4'd0;
            mode_q        <= 1'b1;
            digit_en_q    <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            bcnt_q        <= bcnt_d;
            blink_phase_q <= blink_phase_d;
            slot_val_q    <= slot_val_d;
            slot_mode_q   <= slot_mode_d;
            value_q       <= value_d;
            mode_q        <= mode_d;
            digit_en_q    <= digit_en_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign value      = value_q;
    assign mode       = mode_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [3:0]    wr_value = '0;
    logic          wr_mode = 1'b0;
    logic          clear = 1'b0;
    logic [ND-1:0] blink_mask = '0;
    logic [3:0]    value;
    logic          mode;
    logic [ND-1:0] digit_en;
    logic          frame_tick;

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_value(wr_value), .wr_mode(wr_mode), .clear(clear),
        .blink_mask(blink_mask), .value(value), .mode(mode),
        .digit_en(digit_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic       ft;
    } scan_vec_t;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] val;
        logic       md;
    } wr_vec_t;

    typedef logic [3:0][3:0] val4_t;

    int n_chk  = 0;
    int n_fail = 0;
    int n      = 0;   // edges since reset release

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    // One full frame; expected digit/blank pattern follows from edges since release.
    task automatic check_frame(input string nm, input val4_t ev, input logic [3:0] em);
        for (int k = 0; k < 16; k++) begin
            int d, p;
            tick();
            p = (n - 1) % 4;
            d = ((n - 1) / 4) % 4;
            chk({nm, " ft"}, 32'(frame_tick), 32'(((n - 1) % 16) == 15));
            if (p == 0) begin
                chk({nm, " gap en"}, 32'(digit_en), 32'h0);
            end else begin
                chk({nm, " en"}, 32'(digit_en), 32'(1 << d));
                chk({nm, " value"}, 32'(value), 32'(ev[d]));
                chk({nm, " mode"}, 32'(mode), 32'(em[d]));
            end
        end
    endtask

    scan_vec_t scan_tab[16];
    wr_vec_t   wr_tab[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        val4_t ev;
        logic [3:0] em;

        // Reset scan pattern: gap, then three enabled cycles per digit.
        scan_tab[0]  = '{4'h0, 1'b0}; scan_tab[1]  = '{4'h1, 1'b0};
        scan_tab[2]  = '{4'h1, 1'b0}; scan_tab[3]  = '{4'h1, 1'b0};
        scan_tab[4]  = '{4'h0, 1'b0}; scan_tab[5]  = '{4'h2, 1'b0};
        scan_tab[6]  = '{4'h2, 1'b0}; scan_tab[7]  = '{4'h2, 1'b0};
        scan_tab[8]  = '{4'h0, 1'b0}; scan_tab[9]  = '{4'h4, 1'b0};
        scan_tab[10] = '{4'h4, 1'b0}; scan_tab[11] = '{4'h4, 1'b0};
        scan_tab[12] = '{4'h0, 1'b0}; scan_tab[13] = '{4'h8, 1'b0};
        scan_tab[14] = '{4'h8, 1'b0}; scan_tab[15] = '{4'h8, 1'b1};

        wr_tab[0] = '{3'd0, 4'h1, 1'b0};
        wr_tab[1] = '{3'd1, 4'h2, 1'b0};
        wr_tab[2] = '{3'd2, 4'hC, 1'b1};
        wr_tab[3] = '{3'd3, 4'h5, 1'b1};
        wr_tab[4] = '{3'd5, 4'hF, 1'b0};   // out of range, must be dropped

        // Reset state
        tick(); tick();
        chk("rst value", 32'(value), 32'h0);
        chk("rst mode", 32'(mode), 32'h1);
        chk("rst en", 32'(digit_en), 32'h0);
        chk("rst ft", 32'(frame_tick), 32'h0);

        // Reset scan, two frames
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("scan en", 32'(digit_en), 32'(scan_tab[k % 16].en));
            chk("scan ft", 32'(frame_tick), 32'(scan_tab[k % 16].ft));
            chk("scan value", 32'(value), 32'h0);
            chk("scan mode", 32'(mode), 32'h1);
        end

        // Writes
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_addr = wr_tab[k].addr;
            wr_value = wr_tab[k].val; wr_mode = wr_tab[k].md;
            tick();
        end
        wr_en = 1'b0;
        ev = '0; ev[0] = 4'h1; ev[1] = 4'h2; ev[2] = 4'hC; ev[3] = 4'h5;
        check_frame("writes", ev, 4'b1100);

        // Live update within digit 1's window
        for (int k = 0; k < 32 && ((n - 1) % 16) != 5; k++) tick();
        chk("live align", 32'((n - 1) % 16), 32'd5);
        wr_en = 1'b1; wr_addr = 3'd1; wr_value = 4'h7; wr_mode = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("live old value", 32'(value), 32'h2);
        chk("live old en", 32'(digit_en), 32'h2);
        tick();
        chk("live new value", 32'(value), 32'h7);
        chk("live new en", 32'(digit_en), 32'h2);

        // Clear colliding with a write to slot 2
        clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_value = 4'h9; wr_mode = 1'b0;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        ev = '0; ev[2] = 4'h9;
        check_frame("clear", ev, 4'b1011);

        // Blink: fresh reset, slot1={3,0}, slot0={5,0}, mask on digit 1
        rst = 1'b1; blink_mask = 4'b0010;
        tick();
        rst = 1'b0; n = 0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_value = 4'h3; wr_mode = 1'b0;
        tick();
        wr_addr = 3'd0; wr_value = 4'h5;
        tick();
        wr_en = 1'b0;
        while (n < 96) begin
            int d, p, ph;
            tick();
            p  = (n - 1) % 4;
            d  = ((n - 1) / 4) % 4;
            ph = ((n - 1) / 32) % 2;
            if (p != 0) begin
                chk("blink en", 32'(digit_en), 32'(1 << d));
                case (d)
                    0: begin
                        chk("blink d0 value", 32'(value), 32'h5);
                        chk("blink d0 mode", 32'(mode), 32'h0);
                    end
                    1: begin
                        chk("blink d1 value", 32'(value), (ph == 1) ? 32'h0 : 32'h3);
                        chk("blink d1 mode", 32'(mode), (ph == 1) ? 32'h1 : 32'h0);
                    end
                    default: begin
                        chk("blink dx value", 32'(value), 32'h0);
                        chk("blink dx mode", 32'(mode), 32'h1);
                    end
                endcase
            end
        end

        // Reset mid-frame with idx=2, pcnt=2 pending
        blink_mask = '0;
        for (int k = 0; k < 32 && (n % 16) != 10; k++) tick();
        chk("midrst align", 32'(n % 16), 32'd10);
        rst = 1'b1;
        tick();
        chk("midrst en", 32'(digit_en), 32'h0);
        chk("midrst ft", 32'(frame_tick), 32'h0);
        chk("midrst value", 32'(value), 32'h0);
        chk("midrst mode", 32'(mode), 32'h1);
        rst = 1'b0; n = 0;
        check_frame("after rst", '0, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
